div_pipe_scheduler: RTL and testbench
=====================================

DIV_PIPE_SCHEDULER -- requirements
Module: div_pipe_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 9, meaning edges from operand presentation on div_* to result valid on div_quotient/div_reminder.
REQ-002 SHALL have parameter DATA_W, default 8, meaning operand/result width in two's-complement bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  input  1  requester operand valid.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  grant; transfer on valid&&ready at the edge.
REQ-007 SHALL have ports req0_dividend, req0_divisor, req1_dividend, req1_divisor  input  DATA_W  signed operands.
REQ-008 SHALL have port flush  input  1  synchronous discard of all in-flight operations.
REQ-009 SHALL have ports div_dividend / div_divisor  output  DATA_W  registered operands to the pipelined divider.
REQ-010 SHALL have ports div_quotient / div_reminder  input  DATA_W  divider results.
REQ-011 SHALL have ports rsp0_valid / rsp1_valid  output  1  one-cycle result strobe per requester; no backpressure.
REQ-012 SHALL have ports rsp_quotient / rsp_reminder  output  DATA_W  shared result bus, qualified by rspN_valid.
REQ-013 SHALL have port rsp_err  output  1  divide-by-zero flag, qualified by rspN_valid.
REQ-014 SHALL have port inflight  output  4  count of accepted, not yet returned operations.

Function
REQ-015 SHALL grant at most one requester per cycle; ready combinational from valids and rr pointer.
REQ-016 SHALL grant the sole valid requester; when both valid, SHALL grant the one not granted most recently (rr pointer, toggles only on an actual transfer).
REQ-017 SHALL, on transfer at edge k, register the granted operands onto div_* at edge k; div_* hold last value when idle.
REQ-018 SHALL carry a tag {valid, id, err} through a LATENCY-deep shift register advancing every cycle, unconditionally.
REQ-019 SHALL assert rspN_valid (N = tag id) for exactly the cycle following edge k+LATENCY, with rsp_quotient/rsp_reminder = div_quotient/div_reminder sampled that cycle.
REQ-020 SHALL accept one operation per cycle sustained (throughput 1), never stalling; results return in acceptance order.
REQ-021 SHALL increment inflight on transfer, decrement on response, hold when both occur same cycle; max value LATENCY.
REQ-022 SHALL, on flush, clear all tag valids and inflight at that edge; a transfer in the same cycle SHALL be suppressed (ready forced 0 while flush=1).
REQ-023 SHALL deassert both readys during reset; rr pointer favours requester 0 after reset.

Reset
REQ-024 SHALL on rst_n low clear: tag shift register, rspN_valid, rsp_quotient, rsp_reminder, rsp_err, div_dividend, div_divisor, inflight, rr pointer -- all 0.
REQ-025 SHALL discard in-flight operations when reset asserts mid-operation; no response issued after release.

Configuration
REQ-026 SHALL honour macro DIV_PIPE_ZERO_CHECK_EN.
REQ-027 With DIV_PIPE_ZERO_CHECK_EN defined: divisor==0 at transfer SHALL set tag err; operation still occupies its slot; response SHALL give rsp_quotient=all-ones, rsp_reminder=0, rsp_err=1.
REQ-028 Without it: rsp_err SHALL be constant 0 and divider results SHALL pass unmodified.

Structure
REQ-029 SHALL place DATA_W default, LATENCY default, requester-id encoding and the tag struct typedef in shared package div_pipe_pkg.
REQ-030 SHALL implement arbitration in one sub-module rr_arbiter2 (2-way round-robin, grant + pointer update); rest in top.

Verification
REQ-031 Single: req0 100/7 at edge k -> rsp0_valid in cycle after k+9, quotient 14, reminder 2, rsp_err 0.
REQ-032 Signed: req1 -100(0x9C)/7 -> rsp1_valid, quotient 0xF2, reminder 0xFE.
REQ-033 Contention: both valid 6 cycles -> grants alternate 0,1,0,1,0,1; six responses, ids alternate, inflight peaks 6 then returns 0.
REQ-034 Back-to-back: req0 9 consecutive transfers -> inflight reaches 9, then 9 consecutive rsp0_valid in order, results match.
REQ-035 Zero (macro on): req0 50/0 -> rsp0_valid, quotient 0xFF, reminder 0x00, rsp_err 1; macro off -> rsp_err 0.
REQ-036 Flush/reset: 3 ops in flight, flush (or rst_n low) one cycle -> no rsp*_valid for them, inflight 0, next op returns normally.

Source files
------------

// File: rtl/div_pipe_pkg.sv
// Shared types and defaults for the divider pipeline scheduler.
// Holds default widths/latency, requester ids and the in-flight tag.
package div_pipe_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int LATENCY_DEF = 9;

   localparam logic REQ_ID0 = 1'b0;
   localparam logic REQ_ID1 = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
      logic err;
   } tag_t;

   function automatic logic gnt_id(input logic [1:0] gnt);
      return gnt[1] ? REQ_ID1 : REQ_ID0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with combinational grant.
// Ports: clk, rst_n, en (grant enable), req[1:0] in; gnt[1:0] out.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q = 0 favours requester 0 on contention
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt = 2'b00;
      if (en && rst_n) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // gnt implies valid, so any grant is a transfer;
   // point at the requester that was not just served
   always_comb begin
      ptr_d = ptr_q;
      if (|gnt) ptr_d = gnt[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/div_pipe_scheduler.sv
// Shares one fixed-latency pipelined divider between two requesters.
// Ports: clk, rst_n, flush; req0/req1 valid/ready/dividend/divisor;
//   div_dividend/div_divisor out, div_quotient/div_reminder in;
//   rsp0/rsp1 valid, rsp_quotient, rsp_reminder, rsp_err, inflight.
// Option: DIV_PIPE_ZERO_CHECK_EN flags divide-by-zero in the response.
module div_pipe_scheduler
   import div_pipe_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_dividend,
   input  logic [DATA_W-1:0] req0_divisor,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_dividend,
   input  logic [DATA_W-1:0] req1_divisor,
   input  logic              flush,
   output logic [DATA_W-1:0] div_dividend,
   output logic [DATA_W-1:0] div_divisor,
   input  logic [DATA_W-1:0] div_quotient,
   input  logic [DATA_W-1:0] div_reminder,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp_quotient,
   output logic [DATA_W-1:0] rsp_reminder,
   output logic              rsp_err,
   output logic [3:0]        inflight
);

   logic [1:0] gnt;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (~flush),
      .req   ({req1_valid, req0_valid}),
      .gnt   (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];

   logic              xfer;
   logic              sel_id;
   logic [DATA_W-1:0] sel_dvd;
   logic [DATA_W-1:0] sel_dvs;
   tag_t              new_tag;
   tag_t              last_tag;
   logic              rsp_fire;

   tag_t [LATENCY-1:0] tags_q;
   tag_t [LATENCY-1:0] tags_d;
   logic [DATA_W-1:0]  div_dividend_q, div_dividend_d;
   logic [DATA_W-1:0]  div_divisor_q, div_divisor_d;
   logic               rsp0_valid_q, rsp0_valid_d;
   logic               rsp1_valid_q, rsp1_valid_d;
   logic               rsp_err_q, rsp_err_d;
   logic [3:0]         inflight_q, inflight_d;

   always_comb begin
      xfer    = |gnt;
      sel_id  = gnt_id(gnt);
      sel_dvd = (sel_id == REQ_ID1) ? req1_dividend : req0_dividend;
      sel_dvs = (sel_id == REQ_ID1) ? req1_divisor  : req0_divisor;

      new_tag.valid = xfer;
      new_tag.id    = sel_id;
`ifdef DIV_PIPE_ZERO_CHECK_EN
      new_tag.err   = xfer && (sel_dvs == '0);
`else
      new_tag.err   = 1'b0;
`endif

      div_dividend_d = div_dividend_q;
      div_divisor_d  = div_divisor_q;
      if (xfer) begin
         div_dividend_d = sel_dvd;
         div_divisor_d  = sel_dvs;
      end

      // tag line shifts every cycle, no stall path
      tags_d[0] = new_tag;
      for (int i = 1; i < LATENCY; i++) begin
         tags_d[i] = tags_q[i-1];
      end
      if (flush) tags_d = '0;

      last_tag = tags_q[LATENCY-1];
      rsp_fire = last_tag.valid && !flush;

      rsp0_valid_d = rsp_fire && (last_tag.id == REQ_ID0);
      rsp1_valid_d = rsp_fire && (last_tag.id == REQ_ID1);
      rsp_err_d    = rsp_fire && last_tag.err;

      inflight_d = inflight_q;
      if (flush) begin
         inflight_d = '0;
      end else begin
         unique case ({xfer, last_tag.valid})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags_q         <= '0;
         div_dividend_q <= '0;
         div_divisor_q  <= '0;
         rsp0_valid_q   <= 1'b0;
         rsp1_valid_q   <= 1'b0;
         rsp_err_q      <= 1'b0;
         inflight_q     <= '0;
      end else begin
         tags_q         <= tags_d;
         div_dividend_q <= div_dividend_d;
         div_divisor_q  <= div_divisor_d;
         rsp0_valid_q   <= rsp0_valid_d;
         rsp1_valid_q   <= rsp1_valid_d;
         rsp_err_q      <= rsp_err_d;
         inflight_q     <= inflight_d;
      end
   end

   // divider result is live in the strobe cycle, so the
   // result bus is a gated pass-through, zero when idle
   always_comb begin
      rsp_quotient = '0;
      rsp_reminder = '0;
      if (rsp0_valid_q || rsp1_valid_q) begin
`ifdef DIV_PIPE_ZERO_CHECK_EN
         if (rsp_err_q) begin
            rsp_quotient = '1;
            rsp_reminder = '0;
         end else begin
            rsp_quotient = div_quotient;
            rsp_reminder = div_reminder;
         end
`else
         rsp_quotient = div_quotient;
         rsp_reminder = div_reminder;
`endif
      end
   end

   assign div_dividend = div_dividend_q;
   assign div_divisor  = div_divisor_q;
   assign rsp0_valid   = rsp0_valid_q;
   assign rsp1_valid   = rsp1_valid_q;
   // tag err is never set without the zero check, so this stays 0
   assign rsp_err      = rsp_err_q;
   assign inflight     = inflight_q;

endmodule

// File: tb/tb_div_pipe_scheduler.sv
// Bench for div_pipe_scheduler: divider model plus queue-based
// scoreboard, directed scenarios and a randomized run.
module tb_div_pipe_scheduler;

   localparam int L = 9;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_dividend = '0, req0_divisor = '0;
   logic [W-1:0] req1_dividend = '0, req1_divisor = '0;
   logic         flush = 1'b0;
   logic [W-1:0] div_dividend, div_divisor;
   logic [W-1:0] div_quotient, div_reminder;
   logic         rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp_quotient, rsp_reminder;
   logic         rsp_err;
   logic [3:0]   inflight;

   div_pipe_scheduler #(.LATENCY(L), .DATA_W(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_dividend (req0_dividend),
      .req0_divisor  (req0_divisor),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_dividend (req1_dividend),
      .req1_divisor  (req1_divisor),
      .flush         (flush),
      .div_dividend  (div_dividend),
      .div_divisor   (div_divisor),
      .div_quotient  (div_quotient),
      .div_reminder  (div_reminder),
      .rsp0_valid    (rsp0_valid),
      .rsp1_valid    (rsp1_valid),
      .rsp_quotient  (rsp_quotient),
      .rsp_reminder  (rsp_reminder),
      .rsp_err       (rsp_err),
      .inflight      (inflight)
   );

   always #5 clk = ~clk;

   // pipelined divider: result for operands presented after
   // edge k is on the outputs after edge k+L
   logic signed [W-1:0] pd [L];
   logic signed [W-1:0] pv [L];

   function automatic logic [15:0] divide(input logic signed [7:0] a,
                                          input logic signed [7:0] b);
      logic signed [7:0] q, r;
      if (b == 0) return {8'h5A, a};
      q = a / b;
      r = a % b;
      return {q, r};
   endfunction

   always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) begin
         pd[i] <= pd[i-1];
         pv[i] <= pv[i-1];
      end
      pd[0] <= div_dividend;
      pv[0] <= div_divisor;
   end

   always_comb {div_quotient, div_reminder} = divide(pd[L-1], pv[L-1]);

   typedef struct {
      int         due;
      bit         id;
      logic [7:0] a;
      logic [7:0] b;
   } op_t;

   typedef struct {
      int         ec;
      bit         id;
      logic [7:0] q;
      logic [7:0] r;
      logic       e;
   } rsp_t;

   op_t  mq[$];
   rsp_t rlog[$];
   bit   glog[$];
   int   ec = 0;
   bit   last_gnt = 1'b1;
   int   peak = 0;
   int   obs = 0;
   int   vecs = 0;
   int   miss = 0;

   function automatic logic [15:0] rop();
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) b = 8'h00;
      if (a == 8'h80 && b == 8'hFF) b = 8'h01;
      return {a, b};
   endfunction

   task automatic tick(input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                       input bit v1, input logic [7:0] a1, input logic [7:0] b1,
                       input bit fl);
      bit         e0, e1, have;
      op_t        o;
      logic [15:0] d;
      logic [7:0] xq, xr;
      logic       xe;
      req0_valid = v0; req0_dividend = a0; req0_divisor = b0;
      req1_valid = v1; req1_dividend = a1; req1_divisor = b1;
      flush = fl;
      #1;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!fl) begin
         if (v0 && v1) begin
            e0 = last_gnt;
            e1 = !last_gnt;
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      vecs++;
      if ({req1_ready, req0_ready} !== {e1, e0}) begin
         miss++;
         $display("FAIL ready ec=%0d got %b%b want %b%b", ec,
                  req1_ready, req0_ready, e1, e0);
      end
      @(posedge clk);
      ec++;
      have = 1'b0;
      if (fl) mq.delete();
      else if (mq.size() > 0 && mq[0].due == ec) begin
         o = mq.pop_front();
         have = 1'b1;
      end
      if (e0 || e1) begin
         mq.push_back('{ec + L, e1, e1 ? a1 : a0, e1 ? b1 : b0});
         last_gnt = e1;
         glog.push_back(e1);
      end
      xq = '0; xr = '0; xe = 1'b0;
      if (have) begin
         d = divide(o.a, o.b);
         xq = d[15:8];
         xr = d[7:0];
`ifdef DIV_PIPE_ZERO_CHECK_EN
         if (o.b == 8'h00) begin
            xq = 8'hFF;
            xr = 8'h00;
            xe = 1'b1;
         end
`endif
      end
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) obs++;
      vecs++;
      if ({rsp1_valid, rsp0_valid} !== (have ? (o.id ? 2'b10 : 2'b01) : 2'b00)) begin
         miss++;
         $display("FAIL rsp_valid ec=%0d got %b%b want have=%0b id=%0b", ec,
                  rsp1_valid, rsp0_valid, have, o.id);
      end
      if (have) begin
         vecs++;
         if ({rsp_quotient, rsp_reminder, rsp_err} !== {xq, xr, xe}) begin
            miss++;
            $display("FAIL rsp_data ec=%0d got q=%h r=%h e=%b want q=%h r=%h e=%b",
                     ec, rsp_quotient, rsp_reminder, rsp_err, xq, xr, xe);
         end
         rlog.push_back('{ec, o.id, rsp_quotient, rsp_reminder, rsp_err});
      end
      vecs++;
      if (inflight !== 4'(mq.size())) begin
         miss++;
         $display("FAIL inflight ec=%0d got %0d want %0d", ec, inflight, mq.size());
      end
      if (int'(inflight) > peak) peak = int'(inflight);
   endtask

   task automatic idle(input int n);
      repeat (n) tick(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      vecs++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
         miss++;
         $display("FAIL reset_ready got %b%b want 00", req1_ready, req0_ready);
      end
      vecs++;
      if ({rsp1_valid, rsp0_valid, rsp_err, rsp_quotient, rsp_reminder,
           div_dividend, div_divisor, inflight} !== '0) begin
         miss++;
         $display("FAIL reset_outputs got v=%b%b e=%b q=%h r=%h dd=%h dv=%h inf=%0d want all 0",
                  rsp1_valid, rsp0_valid, rsp_err, rsp_quotient, rsp_reminder,
                  div_dividend, div_divisor, inflight);
      end
      @(negedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int k;
      rlog.delete();
      tick(1, 8'd100, 8'd7, 0, 0, 0, 0);
      k = ec;
      idle(L + 2);
      vecs++;
      if (rlog.size() != 1 || rlog[0].ec != k + L || rlog[0].id != 1'b0 ||
          rlog[0].q !== 8'd14 || rlog[0].r !== 8'd2 || rlog[0].e !== 1'b0) begin
         miss++;
         $display("FAIL single n=%0d ec=%0d q=%h r=%h e=%b want n=1 ec=%0d q=0e r=02 e=0",
                  rlog.size(), rlog.size() ? rlog[0].ec : -1,
                  rlog.size() ? rlog[0].q : 8'hxx, rlog.size() ? rlog[0].r : 8'hxx,
                  rlog.size() ? rlog[0].e : 1'bx, k + L);
      end
   endtask

   task automatic test_signed();
      rlog.delete();
      tick(0, 0, 0, 1, 8'h9C, 8'd7, 0);
      idle(L + 2);
      vecs++;
      if (rlog.size() != 1 || rlog[0].id != 1'b1 ||
          rlog[0].q !== 8'hF2 || rlog[0].r !== 8'hFE) begin
         miss++;
         $display("FAIL signed n=%0d id=%0b q=%h r=%h want n=1 id=1 q=f2 r=fe",
                  rlog.size(), rlog.size() ? rlog[0].id : 1'b0,
                  rlog.size() ? rlog[0].q : 8'hxx, rlog.size() ? rlog[0].r : 8'hxx);
      end
   endtask

   task automatic test_contention();
      logic [15:0] p0, p1;
      rlog.delete();
      glog.delete();
      peak = 0;
      repeat (6) begin
         p0 = rop();
         p1 = rop();
         tick(1, p0[15:8], p0[7:0], 1, p1[15:8], p1[7:0], 0);
      end
      vecs++;
      if (glog.size() != 6) begin
         miss++;
         $display("FAIL contention_grants got %0d want 6", glog.size());
      end
      for (int i = 0; i < glog.size(); i++) begin
         vecs++;
         if (glog[i] != 1'(i % 2)) begin
            miss++;
            $display("FAIL contention_order i=%0d got %0b want %0b", i, glog[i], i % 2);
         end
      end
      vecs++;
      if (peak != 6) begin
         miss++;
         $display("FAIL contention_peak got %0d want 6", peak);
      end
      idle(L + 2);
      vecs++;
      if (rlog.size() != 6 || inflight !== 4'd0) begin
         miss++;
         $display("FAIL contention_drain got n=%0d inf=%0d want n=6 inf=0",
                  rlog.size(), inflight);
      end
      for (int i = 0; i < rlog.size(); i++) begin
         vecs++;
         if (rlog[i].id != 1'(i % 2)) begin
            miss++;
            $display("FAIL contention_ids i=%0d got %0b want %0b", i, rlog[i].id, i % 2);
         end
      end
   endtask

   task automatic test_back_to_back();
      rlog.delete();
      peak = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1, 8'(10 * i + 5), 8'(i + 1), 0, 0, 0, 0);
      end
      vecs++;
      if (peak != 9) begin
         miss++;
         $display("FAIL b2b_peak got %0d want 9", peak);
      end
      idle(L + 2);
      vecs++;
      if (rlog.size() != 9) begin
         miss++;
         $display("FAIL b2b_count got %0d want 9", rlog.size());
      end
      for (int i = 0; i < rlog.size(); i++) begin
         vecs++;
         if (rlog[i].id != 1'b0 || rlog[i].ec != rlog[0].ec + i ||
             rlog[i].q !== 8'((10 * i + 5) / (i + 1)) ||
             rlog[i].r !== 8'((10 * i + 5) % (i + 1))) begin
            miss++;
            $display("FAIL b2b_rsp i=%0d got ec=%0d q=%h r=%h want ec=%0d q=%h r=%h",
                     i, rlog[i].ec, rlog[i].q, rlog[i].r, rlog[0].ec + i,
                     8'((10 * i + 5) / (i + 1)), 8'((10 * i + 5) % (i + 1)));
         end
      end
   endtask

   task automatic test_zero();
      logic [7:0] wq, wr;
      logic       we;
`ifdef DIV_PIPE_ZERO_CHECK_EN
      wq = 8'hFF; wr = 8'h00; we = 1'b1;
`else
      wq = 8'h5A; wr = 8'd50; we = 1'b0;
`endif
      rlog.delete();
      tick(1, 8'd50, 8'd0, 0, 0, 0, 0);
      idle(L + 2);
      vecs++;
      if (rlog.size() != 1 || rlog[0].id != 1'b0 || rlog[0].q !== wq ||
          rlog[0].r !== wr || rlog[0].e !== we) begin
         miss++;
         $display("FAIL zero n=%0d q=%h r=%h e=%b want n=1 q=%h r=%h e=%b",
                  rlog.size(), rlog.size() ? rlog[0].q : 8'hxx,
                  rlog.size() ? rlog[0].r : 8'hxx, rlog.size() ? rlog[0].e : 1'bx,
                  wq, wr, we);
      end
   endtask

   task automatic test_flush();
      rlog.delete();
      for (int i = 0; i < 3; i++) tick(1, 8'(20 + i), 8'd3, 0, 0, 0, 0);
      tick(1, 8'd77, 8'd5, 1, 8'd66, 8'd4, 1);
      vecs++;
      if (inflight !== 4'd0) begin
         miss++;
         $display("FAIL flush_inflight got %0d want 0", inflight);
      end
      obs = 0;
      idle(L + 3);
      vecs++;
      if (obs != 0) begin
         miss++;
         $display("FAIL flush_discard got %0d responses want 0", obs);
      end
      tick(1, 8'd100, 8'd7, 0, 0, 0, 0);
      idle(L + 2);
      vecs++;
      if (rlog.size() != 1 || rlog[0].q !== 8'd14 || rlog[0].r !== 8'd2) begin
         miss++;
         $display("FAIL flush_after n=%0d want 1 with q=0e r=02", rlog.size());
      end
   endtask

   task automatic test_reset_mid();
      rlog.delete();
      tick(0, 0, 0, 1, 8'd40, 8'd3, 0);
      for (int i = 0; i < 2; i++) tick(1, 8'(30 + i), 8'd4, 0, 0, 0, 0);
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      vecs++;
      if ({req1_ready, req0_ready} !== 2'b00 || inflight !== 4'd0) begin
         miss++;
         $display("FAIL mid_reset got rdy=%b%b inf=%0d want 00 0",
                  req1_ready, req0_ready, inflight);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ec++;
      mq.delete();
      last_gnt = 1'b1;
      obs = 0;
      idle(L + 3);
      vecs++;
      if (obs != 0) begin
         miss++;
         $display("FAIL mid_reset_discard got %0d responses want 0", obs);
      end
      glog.delete();
      tick(1, 8'd100, 8'd7, 1, 8'd9, 8'd2, 0);
      vecs++;
      if (glog.size() != 1 || glog[0] != 1'b0) begin
         miss++;
         $display("FAIL mid_reset_ptr got n=%0d want grant to req0", glog.size());
      end
      idle(L + 3);
   endtask

   task automatic test_random();
      logic [15:0] p0, p1;
      bit          v0, v1, fl;
      repeat (400) begin
         p0 = rop();
         p1 = rop();
         v0 = ($urandom_range(0, 3) != 0);
         v1 = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 39) == 0);
         tick(v0, p0[15:8], p0[7:0], v1, p1[15:8], p1[7:0], fl);
      end
      idle(L + 2);
   endtask

   initial begin
      for (int i = 0; i < L; i++) begin
         pd[i] = '0;
         pv[i] = '0;
      end
      test_reset();
      test_single();
      test_signed();
      test_contention();
      test_back_to_back();
      test_zero();
      test_flush();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
